updown_seq_ctrl: RTL and testbench

Command sequencer directly upstream of the 4-bit up/down counter: drives its `load`, `mode` and `data` inputs and reads back its `q` output. Accepts LOAD / UP / DOWN commands over a valid/ready handshake and executes each as an exact number of counter steps. Holds the counter still between commands by reloading it with its own value. Reports completion and wrap-around for each command.

---
 rtl/updown_pkg.sv | 18 +
 rtl/updown_seq_ctrl.sv | 106 ++++++++++
 tb/tb_updown_seq_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter command sequencer:
// default width, command opcodes and controller states.
package updown_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/updown_seq_ctrl.sv
// Command sequencer for the up/down counter: runs LOAD/UP/DOWN commands as
// exact step counts and freezes the counter between commands by self-reload.
module updown_seq_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [WIDTH-1:0] q_in,
    output logic             load,
    output logic             mode,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] arg_reg, arg_next;
    logic             up_reg, up_next;
    logic             done_reg, done_next;
    logic             wrap_reg, wrap_next;
    logic             accept;

    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign wrap      = wrap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            arg_reg   <= '0;
            up_reg    <= 1'b0;
            done_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            arg_reg   <= arg_next;
            up_reg    <= up_next;
            done_reg  <= done_next;
            wrap_reg  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        arg_next   = arg_reg;
        up_next    = up_reg;
        done_next  = 1'b0;
        wrap_next  = wrap_reg;
        load       = 1'b1;
        mode       = 1'b0;
        data       = q_in;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    wrap_next = 1'b0;
                    if (cmd_op == OP_LOAD) begin
                        arg_next   = cmd_arg;
                        state_next = LOAD;
                    end else if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_arg != '0) begin
                        rem_next   = cmd_arg;
                        up_next    = (cmd_op == OP_UP);
                        state_next = RUN;
                    end else begin
                        // NOP and zero-step moves complete immediately
                        done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                data       = arg_reg;
                state_next = IDLE;
                done_next  = 1'b1;
            end
            RUN: begin
                load     = 1'b0;
                mode     = up_reg;
                rem_next = rem_reg - WIDTH'(1);
                // q_in is the value about to be stepped, so wrap is seen before it happens
                if ((up_reg && q_in == '1) || (!up_reg && q_in == '0))
                    wrap_next = 1'b1;
                if (rem_reg == WIDTH'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl driving a behavioural model of the
// 4-bit up/down counter it controls.
module tb_updown_seq_ctrl;
    import updown_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic [3:0] q;
    logic       load, mode, busy, done, wrap;
    logic [3:0] data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .q_in(q),
        .load(load), .mode(mode), .data(data),
        .busy(busy), .done(done), .wrap(wrap)
    );

    // Counter model: reset, then load priority, then count up/down
    always_ff @(posedge clk) begin
        if (rst)       q <= 4'd0;
        else if (load) q <= data;
        else if (mode) q <= q + 4'd1;
        else           q <= q - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] arg);
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 4'd0;
        $display("issued op=%0d arg=%0d at t=%0t q=%0d", op, arg, $time, q);
    endtask

    // From the cycle after accept, done must stay low for n cycles then pulse
    task automatic finish(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_done_low"}, done, 0);
            step();
        end
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 4'd0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_load", load, 1);
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_q", q, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_q", q, 0);
            chk("idle_load", load, 1);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_done", done, 0);
        end

        // LOAD 3 then UP 3
        issue(OP_LOAD, 4'd3);
        chk("load3_busy", busy, 1);
        finish(1, "load3");
        chk("load3_q", q, 3);
        issue(OP_UP, 4'd3);
        chk("up3_busy", busy, 1);
        chk("up3_mode", mode, 1);
        chk("up3_load", load, 0);
        finish(3, "up3");
        chk("up3_q", q, 6);
        chk("up3_wrap", wrap, 0);
        step();
        chk("up3_done_drop", done, 0);
        chk("up3_q_stable", q, 6);
        step();
        chk("up3_q_stable2", q, 6);

        // LOAD 14 then UP 4 wraps through 15->0
        issue(OP_LOAD, 4'd14);
        finish(1, "load14");
        chk("load14_q", q, 14);
        issue(OP_UP, 4'd4);
        finish(4, "up4");
        chk("up4_q", q, 2);
        chk("up4_wrap", wrap, 1);

        // LOAD 1 clears wrap on accept, then DOWN 3 wraps through 0->15
        issue(OP_LOAD, 4'd1);
        chk("load1_wrap_cleared", wrap, 0);
        finish(1, "load1");
        chk("load1_q", q, 1);
        issue(OP_DOWN, 4'd3);
        chk("down3_mode", mode, 0);
        finish(3, "down3");
        chk("down3_q", q, 14);
        chk("down3_wrap", wrap, 1);

        // DOWN 0 behaves as NOP
        issue(OP_DOWN, 4'd0);
        chk("down0_done", done, 1);
        chk("down0_busy", busy, 0);
        chk("down0_q", q, 14);
        chk("down0_wrap", wrap, 0);
        step();
        chk("down0_q_after", q, 14);
        chk("down0_done_drop", done, 0);

        // LOAD 8, DOWN 10 aborted by reset four cycles into RUN
        issue(OP_LOAD, 4'd8);
        finish(1, "load8");
        chk("load8_q", q, 8);
        issue(OP_DOWN, 4'd10);
        step(); step(); step();
        chk("abort_q_pre", q, 5);
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        step();
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", cmd_ready, 1);
        chk("abort_wrap", wrap, 0);
        step();
        chk("abort_done_after", done, 0);
        chk("abort_q_after", q, 0);

        // Back-to-back: each command issued in the previous done cycle
        issue(OP_LOAD, 4'd5);
        finish(1, "b2b_load");
        chk("b2b_load_q", q, 5);
        issue(OP_UP, 4'd2);
        finish(2, "b2b_up");
        chk("b2b_up_q", q, 7);
        issue(OP_DOWN, 4'd1);
        finish(1, "b2b_down");
        chk("b2b_down_q", q, 6);
        chk("b2b_down_wrap", wrap, 0);
        step();
        chk("b2b_q_stable", q, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
